packet_serializer: RTL and testbench

- Downstream stage of the queue/selector/scheduler domain: consumes the packet chosen by the selector when the scheduler grants.
- Replays the packet as one AXI4 master transaction on the port toward the memory controller: AW then W beats for a write, AR only for a read.
- Returns a one-cycle consumed pulse to the scheduler once the transaction is fully issued.
- Holds one packet at a time; no response channels are handled here.

---
 rtl/packet_serializer.sv | 183 ++++++++++++++++++
 tb/tb_packet_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_serializer.sv
// Replays one selector packet as a single AXI4 master transaction (AW+W for writes, AR for reads)
// and pulses consumed back to the scheduler once the transaction has been fully issued.
module packet_serializer #(
    parameter int DATA_SIZE   = 102 + (4 * 16) + (4 * 128),
    parameter int HEADER_SIZE = 102,
    parameter int BEATS       = 4,
    parameter int STRB_WIDTH  = 16,
    parameter int BEAT_WIDTH  = 128,
    parameter int ID_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_SIZE-1:0]  packet_in,
    input  logic                  activate,
    output logic                  consumed,
    output logic                  busy,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [39:0]           m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic [ID_WIDTH-1:0]   m_awid,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [BEAT_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wlast,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [39:0]           m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [ID_WIDTH-1:0]   m_arid
);

    localparam int PAYLOAD_W = DATA_SIZE - HEADER_SIZE;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     last_idx;
    logic [CNT_W-1:0]     next_cnt;
    logic [PAYLOAD_W-1:0] payload;

    logic [39:0]          hdr_addr;
    logic [7:0]           hdr_len;
    logic [2:0]           hdr_size;
    logic [1:0]           hdr_burst;
    logic [ID_WIDTH-1:0]  hdr_id;
    logic                 hdr_write;
    logic [CNT_W-1:0]     hdr_last;
    logic                 unused_hdr;

    // Header len beyond the carried beat count is saturated, never forwarded to the bus.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [7:0] len);
        if (len > 8'(BEATS - 1))
            return CNT_W'(BEATS - 1);
        else
            return len[CNT_W-1:0];
    endfunction

    function automatic logic [STRB_WIDTH-1:0] beat_strb(input logic [PAYLOAD_W-1:0] p,
                                                        input logic [CNT_W-1:0] idx);
        return p[int'(idx) * STRB_WIDTH +: STRB_WIDTH];
    endfunction

    function automatic logic [BEAT_WIDTH-1:0] beat_data(input logic [PAYLOAD_W-1:0] p,
                                                        input logic [CNT_W-1:0] idx);
        return p[BEATS * STRB_WIDTH + int'(idx) * BEAT_WIDTH +: BEAT_WIDTH];
    endfunction

    assign hdr_addr   = packet_in[39:0];
    assign hdr_len    = packet_in[47:40];
    assign hdr_size   = packet_in[50:48];
    assign hdr_burst  = packet_in[52:51];
    assign hdr_id     = packet_in[53 +: ID_WIDTH];
    assign hdr_write  = packet_in[HEADER_SIZE-1];
    assign hdr_last   = clamp_len(hdr_len);
    assign unused_hdr = ^packet_in[HEADER_SIZE-2:53+ID_WIDTH];
    assign next_cnt   = beat_cnt + CNT_W'(1);

    // Payload is pure data: captured with the packet, not reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && activate)
            payload <= packet_in[DATA_SIZE-1:HEADER_SIZE];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            last_idx  <= '0;
            consumed  <= 1'b0;
            busy      <= 1'b0;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            m_awsize  <= '0;
            m_awburst <= '0;
            m_awid    <= '0;
            m_wvalid  <= 1'b0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_wlast   <= 1'b0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arid    <= '0;
        end else begin
            consumed <= 1'b0;
            case (state)
                IDLE: begin
                    if (activate) begin
                        busy     <= 1'b1;
                        state    <= ADDR;
                        last_idx <= hdr_last;
                        if (hdr_write) begin
                            m_awvalid <= 1'b1;
                            m_awaddr  <= hdr_addr;
                            m_awlen   <= 8'(hdr_last);
                            m_awsize  <= hdr_size;
                            m_awburst <= hdr_burst;
                            m_awid    <= hdr_id;
                        end else begin
                            m_arvalid <= 1'b1;
                            m_araddr  <= hdr_addr;
                            m_arlen   <= 8'(hdr_last);
                            m_arsize  <= hdr_size;
                            m_arburst <= hdr_burst;
                            m_arid    <= hdr_id;
                        end
                    end
                end
                ADDR: begin
                    if (m_awvalid && m_awready) begin
                        m_awvalid <= 1'b0;
                        state     <= WDATA;
                    end else if (m_arvalid && m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= DONE;
                    end
                end
                WDATA: begin
                    // First WDATA cycle only loads beat 0; wvalid rises after the AW handshake has retired.
                    if (!m_wvalid) begin
                        m_wvalid <= 1'b1;
                        m_wdata  <= beat_data(payload, beat_cnt);
                        m_wstrb  <= beat_strb(payload, beat_cnt);
                        m_wlast  <= (beat_cnt == last_idx);
                    end else if (m_wready) begin
                        if (m_wlast) begin
                            m_wvalid <= 1'b0;
                            m_wlast  <= 1'b0;
                            beat_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            beat_cnt <= next_cnt;
                            m_wdata  <= beat_data(payload, next_cnt);
                            m_wstrb  <= beat_strb(payload, next_cnt);
                            m_wlast  <= (next_cnt == last_idx);
                        end
                    end
                end
                DONE: begin
                    consumed <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: write/read replay, clamping, back-pressure, reset abort, held grant.
module tb_packet_serializer;

    localparam int DATA_SIZE = 102 + (4 * 16) + (4 * 128);

    logic                 clock = 1'b0;
    logic                 reset;
    logic [DATA_SIZE-1:0] packet_in;
    logic                 activate;
    logic                 consumed, busy;
    logic                 m_awvalid, m_awready;
    logic [39:0]          m_awaddr;
    logic [7:0]           m_awlen;
    logic [2:0]           m_awsize;
    logic [1:0]           m_awburst;
    logic [15:0]          m_awid;
    logic                 m_wvalid, m_wready;
    logic [127:0]         m_wdata;
    logic [15:0]          m_wstrb;
    logic                 m_wlast;
    logic                 m_arvalid, m_arready;
    logic [39:0]          m_araddr;
    logic [7:0]           m_arlen;
    logic [2:0]           m_arsize;
    logic [1:0]           m_arburst;
    logic [15:0]          m_arid;

    packet_serializer dut (
        .clock(clock), .reset(reset), .packet_in(packet_in), .activate(activate),
        .consumed(consumed), .busy(busy),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0]  exp_strb [4];
    logic [127:0] exp_data [4];

    int  t_cons, n_cons, n_beats, aw_hs_cnt, ar_hs_cnt, ar_first_k, nb_exp, aw_stall;
    bit  early_w, beat_ok, aw_stable, w_stable, aw_seen, hold_act, w_toggle;
    logic [39:0] awaddr_seen, araddr_seen;
    logic [7:0]  awlen_seen, arlen_seen;
    logic [15:0] awid_seen, arid_seen;
    logic [4:0]  awsb_seen;
    logic [DATA_SIZE-1:0] pkt_b;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_SIZE-1:0] mk(input bit wr, input logic [39:0] addr,
                                                 input logic [7:0] len, input logic [15:0] id);
        logic [DATA_SIZE-1:0] p;
        p          = '0;
        p[39:0]    = addr;
        p[47:40]   = len;
        p[50:48]   = 3'd4;
        p[52:51]   = 2'd1;
        p[68:53]   = id;
        p[100:69]  = '1;
        p[101]     = wr;
        for (int i = 0; i < 4; i++) begin
            p[102 + i*16 +: 16]       = exp_strb[i];
            p[102 + 64 + i*128 +: 128] = exp_data[i];
        end
        return p;
    endfunction

    // Grants one packet, then watches max_cyc cycles (k=0 is the cycle right after the capture edge).
    task automatic run_txn(input logic [DATA_SIZE-1:0] p, input int max_cyc);
        bit p_awv, p_awr, p_wv, p_wr, aw_done;
        logic [39:0]  p_awaddr;
        logic [7:0]   p_awlen;
        logic [15:0]  p_awid;
        logic [127:0] p_wdata;
        t_cons = -1; n_cons = 0; n_beats = 0; aw_hs_cnt = 0; ar_hs_cnt = 0; ar_first_k = -1;
        early_w = 0; beat_ok = 1; aw_stable = 1; w_stable = 1; aw_seen = 0; aw_done = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_awaddr = '0; p_awlen = '0; p_awid = '0; p_wdata = '0;
        awaddr_seen = '0; awlen_seen = '0; awid_seen = '0; awsb_seen = '0;
        araddr_seen = '0; arlen_seen = '0; arid_seen = '0;
        @(negedge clock);
        packet_in = p; activate = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        @(posedge clock);
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clock);
            if (!hold_act) activate = 1'b0;
            m_awready = (k >= aw_stall);
            m_wready  = w_toggle ? (k % 2 == 0) : 1'b1;
            m_arready = 1'b1;
            #1;
            if (consumed) begin
                n_cons++;
                if (n_cons == 1) t_cons = k;
                if (hold_act) begin
                    if (n_cons == 1) packet_in = pkt_b;
                    else activate = 1'b0;
                end
            end
            if (p_awv && !p_awr && (!m_awvalid || m_awaddr != p_awaddr ||
                                    m_awlen != p_awlen || m_awid != p_awid)) aw_stable = 0;
            if (m_awvalid && !aw_seen) begin
                aw_seen = 1; awaddr_seen = m_awaddr; awlen_seen = m_awlen;
                awid_seen = m_awid; awsb_seen = {m_awsize, m_awburst};
            end
            if (m_wvalid && !aw_done) early_w = 1;
            if (p_wv && !p_wr && (!m_wvalid || m_wdata != p_wdata)) w_stable = 0;
            if (m_wvalid && m_wready) begin
                if (n_beats >= 4 || m_wdata !== exp_data[n_beats] || m_wstrb !== exp_strb[n_beats] ||
                    m_wlast !== (n_beats == nb_exp - 1)) beat_ok = 0;
                n_beats++;
            end
            if (m_awvalid && m_awready) begin aw_done = 1; aw_hs_cnt++; end
            if (m_arvalid && ar_first_k < 0) begin
                ar_first_k = k; araddr_seen = m_araddr; arlen_seen = m_arlen; arid_seen = m_arid;
            end
            if (m_arvalid && m_arready) ar_hs_cnt++;
            p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr; p_awlen = m_awlen;
            p_awid = m_awid; p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata;
        end
        activate = 1'b0;
    endtask

    initial begin
        reset = 1'b1; activate = 1'b0; packet_in = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        hold_act = 0; w_toggle = 0; aw_stall = 0; nb_exp = 4; pkt_b = '0;
        for (int i = 0; i < 4; i++) begin
            exp_strb[i] = 16'h1111 << i;
            exp_data[i] = {4{32'hC0DE_0000 + 32'(i)}};
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_consumed", consumed, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_wlast}, 0);
        chk("rst_fields", {m_awaddr, m_araddr, m_awid, m_arid, m_awlen}, 0);
        chk("rst_wdata", m_wdata, 0);
        reset = 1'b0;

        // Write, len=3, all readies high
        nb_exp = 4;
        run_txn(mk(1'b1, 40'h00_0000_1000, 8'd3, 16'h0005), 12);
        chk("w4_consumed_cycle", t_cons, 7);
        chk("w4_consumed_count", n_cons, 1);
        chk("w4_beats", n_beats, 4);
        chk("w4_beat_content", beat_ok, 1);
        chk("w4_awaddr", awaddr_seen, 40'h1000);
        chk("w4_awlen", awlen_seen, 3);
        chk("w4_awid", awid_seen, 16'h0005);
        chk("w4_awsize_burst", awsb_seen, 5'b100_01);
        chk("w4_early_w", early_w, 0);
        chk("w4_no_ar", ar_hs_cnt, 0);

        // Write, len=0, single beat
        exp_strb[0] = 16'h00FF;
        exp_data[0] = {16{8'hA5}};
        nb_exp = 1;
        run_txn(mk(1'b1, 40'h00_0000_2000, 8'd0, 16'h0011), 8);
        chk("w1_awlen", awlen_seen, 0);
        chk("w1_beats", n_beats, 1);
        chk("w1_beat_content", beat_ok, 1);
        chk("w1_consumed_cycle", t_cons, 4);

        // Read, len=7 clamps to 3
        nb_exp = 0;
        run_txn(mk(1'b0, 40'h12_3456_7800, 8'd7, 16'hBEEF), 6);
        chk("rd_arlen", arlen_seen, 3);
        chk("rd_araddr", araddr_seen, 40'h12_3456_7800);
        chk("rd_arid", arid_seen, 16'hBEEF);
        chk("rd_no_w", n_beats, 0);
        chk("rd_no_aw", aw_hs_cnt, 0);
        chk("rd_consumed_cycle", t_cons, 2);
        chk("rd_consumed_count", n_cons, 1);

        // Write with awready stalled and wready toggling
        for (int i = 0; i < 4; i++) begin
            exp_strb[i] = 16'hF000 >> (4 * i);
            exp_data[i] = {2{64'h0123_4567_89AB_CD00 + 64'(i)}};
        end
        nb_exp = 4; aw_stall = 5; w_toggle = 1;
        run_txn(mk(1'b1, 40'h00_0000_3000, 8'd3, 16'h0033), 25);
        chk("bp_aw_stable", aw_stable, 1);
        chk("bp_w_stable", w_stable, 1);
        chk("bp_early_w", early_w, 0);
        chk("bp_beat_order", beat_ok, 1);
        chk("bp_beats", n_beats, 4);
        chk("bp_consumed_count", n_cons, 1);
        chk("bp_consumed_cycle", t_cons, 16);
        aw_stall = 0; w_toggle = 0;

        // Reset during beat 2 of a 4-beat write
        @(negedge clock);
        packet_in = mk(1'b1, 40'h00_0000_4000, 8'd3, 16'h0044); activate = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clock);
            activate = 1'b0;
        end
        chk("ra_beat2_data", m_wdata, exp_data[2]);
        chk("ra_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("ra_valids", {m_awvalid, m_wvalid, m_arvalid, m_wlast}, 0);
        chk("ra_busy", busy, 0);
        chk("ra_consumed", consumed, 0);
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clock);
                if (consumed || m_awvalid || m_wvalid || m_arvalid) stray++;
            end
            chk("ra_quiet_after", stray, 0);
        end
        nb_exp = 0;
        run_txn(mk(1'b0, 40'h00_0000_5000, 8'd2, 16'h0055), 6);
        chk("ra_next_consumed", t_cons, 2);
        chk("ra_next_arlen", arlen_seen, 2);

        // activate held high across two packets
        exp_strb[0] = 16'h00FF;
        exp_data[0] = {16{8'hA5}};
        nb_exp = 1; hold_act = 1;
        pkt_b = mk(1'b0, 40'hAB_CDEF_0000, 8'd1, 16'h0077);
        run_txn(mk(1'b1, 40'h00_0000_6000, 8'd0, 16'h0066), 12);
        hold_act = 0;
        chk("hold_first_consumed", t_cons, 4);
        chk("hold_aw_once", aw_hs_cnt, 1);
        chk("hold_second_ar_cycle", ar_first_k, 5);
        chk("hold_second_araddr", araddr_seen, 40'hAB_CDEF_0000);
        chk("hold_second_arlen", arlen_seen, 1);
        chk("hold_ar_once", ar_hs_cnt, 1);
        chk("hold_consumed_count", n_cons, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
